player_move_grid: RTL and testbench

- Parametrised successor to the per-player motion FSM.
- Converts direction keys into fixed-point player motion, with a configurable speed table, tile-lane snapping (turn assist) and collision rollback to the last legal position.
- Sits between the keypad decoder / collision matrix and the player drawing block; one instance per player.

---
 rtl/player_pkg.sv | 41 ++++
 rtl/player_move_grid_lane_snap.sv | 29 ++
 rtl/player_move_grid.sv | 200 ++++++++++++++++++++
 tb/tb_player_move_grid.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types for the per-player motion block: edge codes, directions and
// FSM states.
package player_pkg;

  localparam logic [3:0] EDGE_LEFT   = 4'b1000;
  localparam logic [3:0] EDGE_TOP    = 4'b0100;
  localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
  localparam logic [3:0] EDGE_BOTTOM = 4'b0001;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_RESOLVE,
    ST_APPLY,
    ST_LIMITS
  } state_e;

  // Wall edge that blocks a step in direction d.
  function automatic logic [3:0] edge_of(input dir_e d);
    logic [3:0] e;
    case (d)
      DIR_DOWN:  e = EDGE_BOTTOM;
      DIR_UP:    e = EDGE_TOP;
      DIR_LEFT:  e = EDGE_LEFT;
      default:   e = EDGE_RIGHT;
    endcase
    return e;
  endfunction

  function automatic logic is_horiz(input dir_e d);
    return (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

endpackage

// File: rtl/player_move_grid_lane_snap.sv
// Turn assist: pulls a pixel coordinate onto the nearest tile lane when it is
// within SNAP_TOL of it; snap_ok low means the turn must be refused.
module lane_snap #(
  parameter int TILE     = 32,
  parameter int SNAP_TOL = 8
) (
  input  logic signed [31:0] pix,
  input  logic signed [31:0] origin,
  output logic signed [31:0] snapped,
  output logic               snap_ok
);

  logic [31:0] off;

  always_comb begin
    // TILE is a power of two, so the mask is a true modulo even for negative offsets.
    off     = (pix - origin) & 32'(TILE - 1);
    snapped = pix;
    snap_ok = 1'b0;
    if (off <= 32'(SNAP_TOL)) begin
      snapped = pix - $signed(off);
      snap_ok = 1'b1;
    end else if (off >= 32'(TILE - SNAP_TOL)) begin
      snapped = pix - $signed(off) + TILE;
      snap_ok = 1'b1;
    end
  end

endmodule

// File: rtl/player_move_grid.sv
// Per-player motion: latches one direction per frame, rolls back on a matching
// wall hit, applies a levelled fixed-point step with lane snapping, clamps to frame.
module player_move_grid
  import player_pkg::*;
#(
  parameter int INITIAL_X    = 15,
  parameter int INITIAL_Y    = 48,
  parameter int FP_SHIFT     = 6,
  parameter int FRAME_LEFT   = 15,
  parameter int FRAME_TOP    = 48,
  parameter int FRAME_RIGHT  = 623,
  parameter int FRAME_BOTTOM = 464,
  parameter int OBJ_W        = 32,
  parameter int OBJ_H        = 32,
  parameter int TILE         = 32,
  parameter int SNAP_TOL     = 8,
  parameter int NUM_SPEEDS   = 4,
  parameter int BASE_SPEED   = 64,
  parameter int SPEED_STEP   = 48,
  localparam int LW = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                game_on,
  input  logic                up_key,
  input  logic                down_key,
  input  logic                left_key,
  input  logic                right_key,
  input  logic                collision,
  input  logic [3:0]          HitEdgeCode,
  input  logic [LW-1:0]       speed_level,
  output logic signed [10:0]  topLeftX,
  output logic signed [10:0]  topLeftY,
  output logic [1:0]          facing,
  output logic                moving,
  output logic [LW-1:0]       current_speed_level
);

  localparam int SPAWN_X = INITIAL_X << FP_SHIFT;
  localparam int SPAWN_Y = INITIAL_Y << FP_SHIFT;
  localparam int MIN_X   = FRAME_LEFT << FP_SHIFT;
  localparam int MAX_X   = (FRAME_RIGHT - OBJ_W) << FP_SHIFT;
  localparam int MIN_Y   = FRAME_TOP << FP_SHIFT;
  localparam int MAX_Y   = (FRAME_BOTTOM - OBJ_H) << FP_SHIFT;
  localparam logic [LW-1:0] MAX_LVL = LW'(NUM_SPEEDS - 1);

  state_e             state_q, state_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic               dir_vld_q, dir_vld_d, last_vld_q, last_vld_d;
  dir_e               dir_q, dir_d, last_q, last_d, facing_q, facing_d;
  logic [3:0]         hit_q, hit_d;
  logic               moving_q, moving_d;
  logic [LW-1:0]      level_q, level_d;

  logic [LW-1:0]      lvl_eff;
  logic signed [31:0] speed, x_pix, y_pix, x_snap, y_snap;
  logic               x_snap_ok, y_snap_ok, step_ok;

  assign x_pix   = x_q >>> FP_SHIFT;
  assign y_pix   = y_q >>> FP_SHIFT;
  assign lvl_eff = (speed_level > MAX_LVL) ? MAX_LVL : speed_level;
  assign speed   = BASE_SPEED + SPEED_STEP * int'(lvl_eff);

  lane_snap #(.TILE(TILE), .SNAP_TOL(SNAP_TOL)) u_snap_x (
    .pix(x_pix), .origin(FRAME_LEFT), .snapped(x_snap), .snap_ok(x_snap_ok)
  );
  lane_snap #(.TILE(TILE), .SNAP_TOL(SNAP_TOL)) u_snap_y (
    .pix(y_pix), .origin(FRAME_TOP), .snapped(y_snap), .snap_ok(y_snap_ok)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    px_d       = px_q;
    py_d       = py_q;
    dir_vld_d  = dir_vld_q;
    dir_d      = dir_q;
    last_vld_d = last_vld_q;
    last_d     = last_q;
    facing_d   = facing_q;
    hit_d      = hit_q;
    moving_d   = moving_q;
    level_d    = level_q;
    step_ok    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d        = SPAWN_X;
        y_d        = SPAWN_Y;
        px_d       = SPAWN_X;
        py_d       = SPAWN_Y;
        dir_vld_d  = 1'b0;
        last_vld_d = 1'b0;
        hit_d      = 4'b0;
        moving_d   = 1'b0;
        if (game_on) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (!dir_vld_q && (up_key || down_key || left_key || right_key)) begin
          dir_vld_d = 1'b1;
          if (up_key)        dir_d = DIR_UP;
          else if (down_key) dir_d = DIR_DOWN;
          else if (left_key) dir_d = DIR_LEFT;
          else               dir_d = DIR_RIGHT;
        end
        if (collision) hit_d = hit_q | HitEdgeCode;
        if (startOfFrame) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        // Only a hit on the edge we were heading into undoes last frame's step.
        if (last_vld_q && |(hit_q & edge_of(last_q))) begin
          x_d = px_q;
          y_d = py_q;
        end
        hit_d   = 4'b0;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        level_d  = lvl_eff;
        px_d     = x_q;
        py_d     = y_q;
        moving_d = 1'b0;
        if (dir_vld_q) begin
          facing_d = dir_q;
          step_ok  = 1'b1;
          if (last_vld_q && (is_horiz(dir_q) != is_horiz(last_q))) begin
            if (is_horiz(dir_q)) begin
              if (y_snap_ok) y_d = y_snap <<< FP_SHIFT;
              else           step_ok = 1'b0;
            end else begin
              if (x_snap_ok) x_d = x_snap <<< FP_SHIFT;
              else           step_ok = 1'b0;
            end
          end
          if (step_ok && speed != 0) begin
            case (dir_q)
              DIR_RIGHT: x_d = x_q + speed;
              DIR_LEFT:  x_d = x_q - speed;
              DIR_DOWN:  y_d = y_q + speed;
              default:   y_d = y_q - speed;
            endcase
            moving_d   = 1'b1;
            last_vld_d = 1'b1;
            last_d     = dir_q;
          end
        end
        dir_vld_d = 1'b0;
        state_d   = ST_LIMITS;
      end
      ST_LIMITS: begin
        if (x_q < MIN_X)      x_d = MIN_X;
        else if (x_q > MAX_X) x_d = MAX_X;
        if (y_q < MIN_Y)      y_d = MIN_Y;
        else if (y_q > MAX_Y) y_d = MAX_Y;
        state_d = game_on ? ST_MOVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      x_q        <= SPAWN_X;
      y_q        <= SPAWN_Y;
      px_q       <= SPAWN_X;
      py_q       <= SPAWN_Y;
      dir_vld_q  <= 1'b0;
      dir_q      <= DIR_DOWN;
      last_vld_q <= 1'b0;
      last_q     <= DIR_DOWN;
      facing_q   <= DIR_DOWN;
      hit_q      <= 4'b0;
      moving_q   <= 1'b0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      dir_vld_q  <= dir_vld_d;
      dir_q      <= dir_d;
      last_vld_q <= last_vld_d;
      last_q     <= last_d;
      facing_q   <= facing_d;
      hit_q      <= hit_d;
      moving_q   <= moving_d;
      level_q    <= level_d;
    end
  end

  assign topLeftX            = 11'(x_q >>> FP_SHIFT);
  assign topLeftY            = 11'(y_q >>> FP_SHIFT);
  assign facing              = facing_q;
  assign moving              = moving_q;
  assign current_speed_level = level_q;

endmodule

// File: tb/tb_player_move_grid.sv
// Frame-level bench for player_move_grid: vector table of frame sequences
// plus hand-written reset / game_on sequences.
module tb_player_move_grid;

  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, game_on = 1'b0;
  logic up_key = 1'b0, down_key = 1'b0, left_key = 1'b0, right_key = 1'b0;
  logic collision = 1'b0;
  logic [3:0] HitEdgeCode = 4'b0;
  logic [1:0] speed_level = 2'd0;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0] facing, current_speed_level;
  logic moving;

  int n_chk = 0, n_pass = 0;

  localparam logic [3:0] K0 = 4'b0000, KU = 4'b1000, KD = 4'b0100, KL = 4'b0010, KR = 4'b0001;

  typedef struct {
    bit rst; logic [3:0] ka, kb; logic [1:0] lvl; logic [3:0] hit, hit2;
    int nfr; int ex, ey; logic [1:0] ef; bit em;
  } vec_t;
  typedef struct { bit last; int ex, ey; logic [1:0] ef; bit em; logic [1:0] el; } exp_t;

  vec_t tbl[19];
  exp_t sb[$];

  player_move_grid dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .game_on(game_on),
    .up_key(up_key), .down_key(down_key), .left_key(left_key), .right_key(right_key),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .speed_level(speed_level),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .facing(facing), .moving(moving),
    .current_speed_level(current_speed_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  function automatic vec_t mk(bit rst, logic [3:0] ka, logic [3:0] kb, logic [1:0] lvl,
                              logic [3:0] hit, logic [3:0] hit2, int nfr, int ex, int ey,
                              logic [1:0] ef, bit em);
    vec_t v;
    v.rst = rst; v.ka = ka; v.kb = kb; v.lvl = lvl; v.hit = hit; v.hit2 = hit2;
    v.nfr = nfr; v.ex = ex; v.ey = ey; v.ef = ef; v.em = em;
    return v;
  endfunction

  task automatic set_keys(input logic [3:0] k);
    {up_key, down_key, left_key, right_key} = k;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; game_on = 1'b0; set_keys(K0);
    startOfFrame = 1'b0; collision = 1'b0; HitEdgeCode = 4'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1; game_on = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Four MOVE cycles (first with ka, rest kb), then the frame pulse, then
  // three clocks for RESOLVE/APPLY/LIMITS; returns on the negedge after LIMITS.
  task automatic drive_frame(input logic [3:0] ka, input logic [3:0] kb,
                             input logic [3:0] hit, input logic [3:0] hit2);
    for (int c = 0; c < 4; c++) begin
      set_keys(c == 0 ? ka : kb);
      collision   = (c == 1 && hit != 4'b0) || (c == 3 && hit2 != 4'b0);
      HitEdgeCode = (c == 1) ? hit : (c == 3) ? hit2 : 4'b0;
      @(negedge clk);
    end
    collision = 1'b0; HitEdgeCode = 4'b0;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0; set_keys(K0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    exp_t e, got;
    if (v.rst) do_reset();
    speed_level = v.lvl;
    for (int f = 0; f < v.nfr; f++) begin
      e.last = (f == v.nfr - 1); e.ex = v.ex; e.ey = v.ey;
      e.ef = v.ef; e.em = v.em; e.el = v.lvl;
      sb.push_back(e);
      drive_frame(v.ka, v.kb, (f == 0) ? v.hit : 4'b0, (f == 0) ? v.hit2 : 4'b0);
      got = sb.pop_front();
      check($sformatf("r%0d_f%0d_moving", idx, f), int'(moving), int'(got.em));
      check($sformatf("r%0d_f%0d_facing", idx, f), int'(facing), int'(got.ef));
      if (got.last) begin
        check($sformatf("r%0d_x", idx), int'(topLeftX), got.ex);
        check($sformatf("r%0d_y", idx), int'(topLeftY), got.ey);
        check($sformatf("r%0d_level", idx), int'(current_speed_level), int'(got.el));
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1, K0, K0, 0, 4'b0, 4'b0, 3, 15, 48, 0, 0);
    tbl[1]  = mk(1, KR, KR, 0, 4'b0, 4'b0, 10, 25, 48, 3, 1);
    tbl[2]  = mk(1, KR, KR, 3, 4'b0, 4'b0, 4, 28, 48, 3, 1);
    tbl[3]  = mk(1, KR, KR, 0, 4'b0, 4'b0, 1, 16, 48, 3, 1);
    tbl[4]  = mk(0, K0, K0, 0, 4'b0010, 4'b0010, 1, 15, 48, 3, 0);
    tbl[5]  = mk(1, KR, KR, 0, 4'b0, 4'b0, 1, 16, 48, 3, 1);
    tbl[6]  = mk(0, K0, K0, 0, 4'b0100, 4'b0100, 1, 16, 48, 3, 0);
    tbl[7]  = mk(1, KD, KD, 0, 4'b0, 4'b0, 5, 15, 53, 0, 1);
    tbl[8]  = mk(0, KR, KR, 0, 4'b0, 4'b0, 1, 16, 48, 3, 1);
    tbl[9]  = mk(1, KD, KD, 0, 4'b0, 4'b0, 12, 15, 60, 0, 1);
    tbl[10] = mk(0, KR, KR, 0, 4'b0, 4'b0, 1, 15, 60, 3, 0);
    tbl[11] = mk(1, KU, KU, 0, 4'b0, 4'b0, 1, 15, 48, 1, 1);
    tbl[12] = mk(1, KL, KL, 0, 4'b0, 4'b0, 2, 15, 48, 2, 1);
    tbl[13] = mk(1, KD | KR, KD | KR, 0, 4'b0, 4'b0, 1, 15, 49, 0, 1);
    tbl[14] = mk(1, KR, KR, 3, 4'b0, 4'b0, 200, 591, 48, 3, 1);
    tbl[15] = mk(1, KD, KD, 3, 4'b0, 4'b0, 150, 15, 432, 0, 1);
    tbl[16] = mk(1, KR, KR, 0, 4'b0, 4'b0, 2, 17, 48, 3, 1);
    tbl[17] = mk(0, KL, KR, 0, 4'b0, 4'b0, 1, 16, 48, 2, 1);
    tbl[18] = mk(0, K0, K0, 0, 4'b1000, 4'b0001, 1, 17, 48, 2, 0);

    // Reset values while resetN is held low.
    repeat (2) @(negedge clk);
    check("rst_x", int'(topLeftX), 15);
    check("rst_y", int'(topLeftY), 48);
    check("rst_facing", int'(facing), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_level", int'(current_speed_level), 0);

    for (int i = 0; i < 19; i++) run_row(i, tbl[i]);

    // Asynchronous reset while the FSM sits in APPLY.
    do_reset();
    speed_level = 2'd0;
    drive_frame(KR, KR, 4'b0, 4'b0);
    drive_frame(KR, KR, 4'b0, 4'b0);
    right_key = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0; right_key = 1'b0;
    @(negedge clk);
    check("pre_async_x", int'(topLeftX), 17);
    check("pre_async_moving", int'(moving), 1);
    resetN = 1'b0;
    #1;
    check("async_x", int'(topLeftX), 15);
    check("async_y", int'(topLeftY), 48);
    check("async_moving", int'(moving), 0);
    check("async_facing", int'(facing), 0);

    // game_on falls mid-frame: frame completes, then spawn position returns.
    do_reset();
    drive_frame(KR, KR, 4'b0, 4'b0);
    drive_frame(KR, KR, 4'b0, 4'b0);
    game_on = 1'b0;
    drive_frame(KR, KR, 4'b0, 4'b0);
    check("goff_frame_done_x", int'(topLeftX), 18);
    @(negedge clk);
    check("goff_idle_x", int'(topLeftX), 15);
    check("goff_idle_y", int'(topLeftY), 48);
    check("goff_idle_moving", int'(moving), 0);
    drive_frame(KR, KR, 4'b0, 4'b0);
    check("goff_hold_x", int'(topLeftX), 15);
    game_on = 1'b1;
    repeat (2) @(negedge clk);
    drive_frame(KR, KR, 4'b0, 4'b0);
    check("resume_x", int'(topLeftX), 16);
    check("resume_moving", int'(moving), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
